periph_reg_responder: RTL
=========================

PERIPH_REG_RESPONDER -- requirements
Module: periph_reg_responder

Interface
REQ-001 The block SHALL have parameter CTRL_RESET, default 32'h0000_0000, giving the reset value of CTRL.
REQ-002 The block SHALL have parameter IRQ_EN_RESET, default 32'h0000_0000, giving the reset value of IRQ_EN.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a bus request is present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr, input, 6 bits: [5:4] register select, [3:2] access alias (0 MAIN, 1 SET, 2 CLR, 3 INV), [1:0] ignored.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: write data.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: a response is present.
REQ-011 The block SHALL have port resp_ready, input, 1 bit: the initiator accepts the response.
REQ-012 The block SHALL have port resp_rdata, output, 32 bits: read data; 0 for writes.
REQ-013 The block SHALL have port resp_err, output, 1 bit: error response.
REQ-014 The block SHALL have port ctrl_out, output, 32 bits: current CTRL value.
REQ-015 The block SHALL have port status_in, input, 32 bits: hardware status, read-only to software.
REQ-016 The block SHALL have port irq_event, input, 32 bits: per-bit one-cycle pulses that set IRQ_FLAGS bits.
REQ-017 The block SHALL have port irq, output, 1 bit: the interrupt request.

Function
REQ-018 The register map SHALL be, by req_addr[5:4]: 0 CTRL, 1 STATUS, 2 IRQ_FLAGS, 3 IRQ_EN.
REQ-019 The FSM SHALL have two states, IDLE and RESP.
REQ-020 In IDLE, req_ready SHALL be 1 and resp_valid SHALL be 0.
REQ-021 In RESP, req_ready SHALL be 0 and resp_valid SHALL be 1.
REQ-022 A request SHALL be accepted on a rising edge in IDLE with req_valid=1; the write effect, resp_rdata and resp_err SHALL all be captured on that same edge, and the FSM SHALL go to RESP.
REQ-023 In RESP, the FSM SHALL return to IDLE on the edge where resp_ready=1.
REQ-024 resp_rdata and resp_err SHALL stay stable while in RESP.
REQ-025 Only one request SHALL be outstanding; the minimum time per transaction is 2 cycles.
REQ-026 CTRL and IRQ_EN writes SHALL update each bit by its alias: MAIN = wdata; SET = cur | wdata; CLR = cur & ~wdata; INV = cur ^ wdata.
REQ-027 An IRQ_FLAGS write with alias MAIN, CLR or INV SHALL clear the bits where wdata is 1 (clear-only).
REQ-028 An IRQ_FLAGS write with alias SET SHALL leave the flags unchanged and SHALL NOT raise an error.
REQ-029 A STATUS write SHALL change nothing and SHALL respond with resp_err=1.
REQ-030 All other accesses SHALL respond with resp_err=0.
REQ-031 A read SHALL return the selected register's value from before the accept edge; the alias bits SHALL be ignored for reads.
REQ-032 A STATUS read SHALL return status_in as sampled at the accept edge.
REQ-033 Each cycle, IRQ_FLAGS SHALL be set where irq_event=1.
REQ-034 When an irq_event bit and a software clear of the same bit occur in the same cycle, the event SHALL win and the bit SHALL end at 1.
REQ-035 irq SHALL be combinational: irq = |(IRQ_FLAGS & IRQ_EN).
REQ-036 ctrl_out SHALL be driven directly from the CTRL register.
REQ-037 req_valid in RESP SHALL be ignored and held off by req_ready=0; a request held through RESP SHALL be accepted on the first IDLE edge.

Reset
REQ-038 While rst=1, asynchronously: FSM = IDLE, CTRL = CTRL_RESET, IRQ_EN = IRQ_EN_RESET, IRQ_FLAGS = 0, resp_rdata = 0, resp_err = 0.
REQ-039 Reset asserted in RESP SHALL drop the pending response immediately (resp_valid=0), with no register side effects beyond the reset values.
REQ-040 After rst deasserts, the first request SHALL be acceptable on the next rising edge.

Verification
REQ-041 The bench SHALL cover: CTRL=0, write addr 0x00 wdata 0xF0F0_0000; write SET 0x04 wdata 0x0000_000F; write CLR 0x08 wdata 0x0000_0003; write INV 0x0C wdata 0xFFFF_FFFF -> ctrl_out=0x0F0F_FFF3; read 0x00 returns the same.
REQ-042 The bench SHALL cover: irq_event=0x0000_0005 for one cycle, IRQ_EN written 0x4 -> irq=1; write IRQ_FLAGS SET alias 0x24 wdata 0x2 -> flags stay 0x5; write CLR 0x28 wdata 0x4 -> flags=0x1, irq=0.
REQ-043 The bench SHALL cover: irq_event bit 0 pulsed on the same edge as a MAIN write 0x20 wdata 0x1 -> flag bit 0 stays 1.
REQ-044 The bench SHALL cover: write STATUS 0x10 -> resp_err=1, no register change; read 0x10 with status_in=0xDEAD_BEEF -> resp_rdata=0xDEAD_BEEF, resp_err=0.
REQ-045 The bench SHALL cover: resp_ready held 0 for 5 cycles with req_valid=1 -> req_ready=0 and rdata stable throughout; the next request is accepted only after the resp_ready=1 edge.
REQ-046 The bench SHALL cover: rst pulsed while in RESP after a CTRL write of 0x1 -> resp_valid=0 at once, ctrl_out=CTRL_RESET, IRQ_FLAGS=0.

Source files
------------

// File: rtl/periph_reg_responder.sv
// Memory-mapped peripheral register block: CTRL, STATUS, IRQ_FLAGS, IRQ_EN with
// SET/CLR/INV access aliases and a single-outstanding request/response handshake.
module periph_reg_responder #(
    parameter logic [31:0] CTRL_RESET   = 32'h0000_0000,
    parameter logic [31:0] IRQ_EN_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [5:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ctrl_out,
    input  logic [31:0] status_in,
    input  logic [31:0] irq_event,
    output logic        irq,
    output logic [0:0]  dbg_state_o
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where resp_valid && resp_ready.
    // req_ready and resp_valid are mutually exclusive, so one transaction is in flight.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_FLAGS  = 2'd2;
    localparam logic [1:0] SEL_IRQ_EN = 2'd3;

    localparam logic [1:0] AL_MAIN = 2'd0;
    localparam logic [1:0] AL_SET  = 2'd1;
    localparam logic [1:0] AL_CLR  = 2'd2;

    logic [0:0]  state_q, state_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] irq_en_q, irq_en_d;
    logic [31:0] flags_q, flags_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic [1:0]  sel;
    logic [1:0]  alias_sel;
    logic        unused_addr_bits;

    assign sel              = req_addr[5:4];
    assign alias_sel        = req_addr[3:2];
    assign unused_addr_bits = ^req_addr[1:0];
    assign accept           = (state_q == ST_IDLE) && req_valid;

    function automatic logic [31:0] apply_alias(input logic [1:0]  al,
                                                input logic [31:0] cur,
                                                input logic [31:0] wd);
        logic [31:0] res;
        case (al)
            AL_MAIN: res = wd;
            AL_SET:  res = cur | wd;
            AL_CLR:  res = cur & ~wd;
            default: res = cur ^ wd;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        irq_en_d = irq_en_q;
        flags_d  = flags_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_RESP;
            default: if (resp_ready) state_d = ST_IDLE;
        endcase

        if (accept) begin
            err_d   = req_write && (sel == SEL_STATUS);
            rdata_d = 32'h0;
            if (req_write) begin
                case (sel)
                    SEL_CTRL:   ctrl_d   = apply_alias(alias_sel, ctrl_q, req_wdata);
                    SEL_IRQ_EN: irq_en_d = apply_alias(alias_sel, irq_en_q, req_wdata);
                    SEL_FLAGS:  if (alias_sel != AL_SET) flags_d = flags_q & ~req_wdata;
                    default:    ;
                endcase
            end else begin
                case (sel)
                    SEL_CTRL:   rdata_d = ctrl_q;
                    SEL_STATUS: rdata_d = status_in;
                    SEL_FLAGS:  rdata_d = flags_q;
                    default:    rdata_d = irq_en_q;
                endcase
            end
        end

        // Events are OR-ed in after the software clear so a same-cycle event wins.
        flags_d = flags_d | irq_event;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= CTRL_RESET;
            irq_en_q <= IRQ_EN_RESET;
            flags_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            irq_en_q <= irq_en_d;
            flags_q  <= flags_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign resp_valid  = (state_q == ST_RESP);
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign ctrl_out    = ctrl_q;
    assign irq         = |(flags_q & irq_en_q);
    assign dbg_state_o = state_q;

endmodule
